// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core LSU (m0)
// and a secondary master (m1); generates the core stall and per-access timeouts.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wd_i,
  output logic [31:0] m0_rd_o,
  output logic        m0_stall_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wd_i,
  output logic [31:0] m1_rd_o,
  output logic        m1_ready_o,
  output logic        m1_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT0, WAIT1} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_prio, w_prio_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_we;
  logic [3:0]      r_be;
  logic [31:0]     r_addr, r_wd;

  logic            w_gnt0, w_gnt1, w_timeout;
  logic            w_we;
  logic [3:0]      w_be;
  logic [31:0]     w_addr, w_wd;

  // prio=0 favours m0 on a tie, prio=1 favours m1
  assign w_gnt0 = m0_req_i & ~(m1_req_i & r_prio);
  assign w_gnt1 = m1_req_i & ~(m0_req_i & ~r_prio);

  assign w_we   = w_gnt1 ? m1_we_i   : m0_we_i;
  assign w_be   = w_gnt1 ? m1_be_i   : m0_be_i;
  assign w_addr = w_gnt1 ? m1_addr_i : m0_addr_i;
  assign w_wd   = w_gnt1 ? m1_wd_i   : m0_wd_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we   <= 1'b0;
      r_be   <= '0;
      r_addr <= '0;
      r_wd   <= '0;
    end else if (r_state == IDLE && (w_gnt0 || w_gnt1)) begin
      r_we   <= w_we;
      r_be   <= w_be;
      r_addr <= w_addr;
      r_wd   <= w_wd;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_cnt_nxt   = r_cnt;
    w_timeout   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wd_o    = '0;
    m0_rd_o     = '0;
    m0_err_o    = 1'b0;
    m1_rd_o     = '0;
    m1_ready_o  = 1'b0;
    m1_err_o    = 1'b0;
    case (r_state)
      IDLE: begin
        // reset gating keeps the port quiet while rst_i is held with requests pending
        if (!rst_i && (w_gnt0 || w_gnt1)) begin
          mem_req_o   = 1'b1;
          mem_we_o    = w_we;
          mem_be_o    = w_be;
          mem_addr_o  = w_addr;
          mem_wd_o    = w_wd;
          w_state_nxt = w_gnt1 ? WAIT1 : WAIT0;
          w_cnt_nxt   = '0;
        end
      end
      WAIT0, WAIT1: begin
        mem_req_o  = 1'b1;
        mem_we_o   = r_we;
        mem_be_o   = r_be;
        mem_addr_o = r_addr;
        mem_wd_o   = r_wd;
        w_timeout  = (TIMEOUT != 0) && !mem_ready_i && (r_cnt == CW'(TIMEOUT - 1));
        if (r_state == WAIT0) begin
          m0_rd_o  = mem_ready_i ? mem_rd_i : '0;
          m0_err_o = w_timeout;
        end else begin
          m1_rd_o    = mem_ready_i ? mem_rd_i : '0;
          m1_ready_o = mem_ready_i;
          m1_err_o   = w_timeout;
        end
        if (mem_ready_i || w_timeout) begin
          w_state_nxt = IDLE;
          w_prio_nxt  = (r_state == WAIT0);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign m0_stall_o = m0_req_i & ~((r_state == WAIT0) & (mem_ready_i | w_timeout));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level model of the
// shared port (owner, aged latched command, round-robin "served last").
module tb_dmem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_addr_i, m0_wd_i, m1_addr_i, m1_wd_i;
  logic [31:0] m0_rd_o, m1_rd_o, mem_addr_o, mem_wd_o, mem_rd_i;
  logic        m0_stall_o, m0_err_o, m1_ready_o, m1_err_o;
  logic        mem_req_o, mem_we_o, mem_ready_i;
  logic [3:0]  mem_be_o;

  dmem_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_addr_i(m0_addr_i), .m0_wd_i(m0_wd_i), .m0_rd_o(m0_rd_o),
    .m0_stall_o(m0_stall_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i), .m1_wd_i(m1_wd_i), .m1_rd_o(m1_rd_o),
    .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Model state: who owns the port (-1 none), its command, cycles waited, last served
  int          own = -1;
  int          last = 1;
  int unsigned age = 0;
  logic [68:0] held = '0;
  logic        done0, done1;

  task automatic model_step();
    logic [68:0] c0, c1, e_cmd;
    logic        e_req, e_stall, e_err0, e_err1, e_rdy1, rdy, to;
    logic [31:0] e_rd0, e_rd1;
    int          win;
    c0 = {m0_we_i, m0_be_i, m0_addr_i, m0_wd_i};
    c1 = {m1_we_i, m1_be_i, m1_addr_i, m1_wd_i};
    e_cmd = '0; e_req = 0; e_err0 = 0; e_err1 = 0; e_rdy1 = 0;
    e_rd0 = '0; e_rd1 = '0; e_stall = m0_req_i;
    done0 = 0; done1 = 0;
    if (rst_i) begin
      own = -1; last = 1; age = 0; held = '0;
      done0 = 1; done1 = 1;
    end else if (own < 0) begin
      if (m0_req_i || m1_req_i) begin
        if (m0_req_i && m1_req_i) win = (last == 0) ? 1 : 0;
        else win = m0_req_i ? 0 : 1;
        e_req = 1;
        e_cmd = (win == 1) ? c1 : c0;
        held  = e_cmd;
        own   = win;
        age   = 0;
      end
    end else begin
      e_req = 1;
      e_cmd = held;
      rdy = mem_ready_i;
      to  = !rdy && (age + 1 == TO);
      if (own == 0) begin
        e_rd0 = rdy ? mem_rd_i : '0;
        e_err0 = to;
        e_stall = m0_req_i && !(rdy || to);
      end else begin
        e_rd1 = rdy ? mem_rd_i : '0;
        e_rdy1 = rdy;
        e_err1 = to;
      end
      if (rdy || to) begin
        done0 = (own == 0);
        done1 = (own == 1);
        last = own;
        own = -1;
      end else begin
        age++;
      end
    end
    check("mem_req",  128'(mem_req_o), 128'(e_req));
    check("mem_cmd",  128'({mem_we_o, mem_be_o, mem_addr_o, mem_wd_o}), 128'(e_cmd));
    check("m0_rd",    128'(m0_rd_o), 128'(e_rd0));
    check("m0_stall", 128'(m0_stall_o), 128'(e_stall));
    check("m0_err",   128'(m0_err_o), 128'(e_err0));
    check("m1_rd",    128'(m1_rd_o), 128'(e_rd1));
    check("m1_ready", 128'(m1_ready_o), 128'(e_rdy1));
    check("m1_err",   128'(m1_err_o), 128'(e_err1));
  endtask

  // One cycle: drive at negedge (rst_i lands mid-cycle, i.e. asynchronously), check #1 later
  task automatic cycle(input logic rst, input logic r0, input logic r1, input logic allow_rdy);
    @(negedge clk);
    rst_i     = rst;
    m0_req_i  = r0;
    m1_req_i  = r1;
    m0_we_i   = 1'($urandom);
    m0_be_i   = 4'($urandom);
    m0_addr_i = $urandom;
    m0_wd_i   = $urandom;
    m1_we_i   = 1'($urandom);
    m1_be_i   = 4'($urandom);
    m1_addr_i = $urandom;
    m1_wd_i   = $urandom;
    mem_rd_i  = $urandom;
    mem_ready_i = allow_rdy && ($urandom_range(0, 9) < 4);
    #1;
    model_step();
  endtask

  logic q0, q1;

  initial begin
    rst_i = 1'b1; m0_req_i = 0; m1_req_i = 0; mem_ready_i = 0;
    m0_we_i = 0; m0_be_i = '0; m0_addr_i = '0; m0_wd_i = '0;
    m1_we_i = 0; m1_be_i = '0; m1_addr_i = '0; m1_wd_i = '0; mem_rd_i = '0;
    cycle(1, 0, 0, 1);
    cycle(1, 1, 1, 1);
    // Reset while m1 owns the port: no pulses, m0 wins the first tie afterwards
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 1);
    q0 = 1; q1 = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!q0 || done0) q0 = 1'($urandom);
      if (!q1 || done1) q1 = 1'($urandom);
      cycle(($urandom_range(0, 99) == 0), q0, q1, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
